// File: rtl/rx_block_pkg.sv
// Shared types and constants for the 64b/66b Rx block-lock path.
// Sync headers, lock-FSM states and buffer geometry live here.
package rx_block_pkg;

   localparam logic [1:0]  C_DATA_HEADER = 2'b01;
   localparam logic [1:0]  C_CMD_HEADER  = 2'b10;

   localparam int unsigned BUF_W  = 194;
   localparam int unsigned OFFS_W = 7;
   localparam int unsigned BLK_W  = 64;
   localparam int unsigned CNT_W  = 6;

   typedef enum logic [1:0] {
      HUNT,
      CHECK,
      LOCKED
   } sync_state_t;

   function automatic logic hdr_good(input logic [1:0] hdr);
      return (hdr == C_DATA_HEADER) || (hdr == C_CMD_HEADER);
   endfunction

endpackage

// File: rtl/block_slicer.sv
// Combinational 66b block extractor: picks the 2b header and 64b payload out of the
// gearbox buffer for a given header offset and buffer view index.
module block_slicer
   import rx_block_pkg::*;
(
   input  logic [BUF_W-1:0]  gbox_buffer_i,
   input  logic [CNT_W-1:0]  gbox_cnt_i,
   input  logic [OFFS_W-1:0] offset_i,
   output logic [1:0]        hdr_o,
   output logic [BLK_W-1:0]  data_o,
   output logic              hdr_ok_o
);

   logic [7:0] base;

   // base stays within 64..192 for cnt 0..63 and offset 0..65
   always_comb begin
      base     = 8'd127 - {2'b00, gbox_cnt_i} + {1'b0, offset_i};
      hdr_o    = gbox_buffer_i[base + 8'd1 -: 2];
      data_o   = gbox_buffer_i[base - 8'd1 -: BLK_W];
      hdr_ok_o = hdr_good(hdr_o);
   end

endmodule

// File: rtl/block_sync.sv
// 66b block-lock FSM (HUNT/CHECK/LOCKED) feeding the decoder with aligned blocks.
// Outputs are registered and update one cycle after the accepted buffer strobe.
module block_sync
   import rx_block_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 32,
   parameter int unsigned ERR_MAX  = 16,
   parameter int unsigned WINDOW   = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [BUF_W-1:0]  gbox_buffer,
   input  logic [CNT_W-1:0]  gbox_cnt,
   input  logic              buffer_dv,
   input  logic [OFFS_W-1:0] block_offset,
   input  logic              relock_i,
   output logic [BLK_W-1:0]  blk_data_o,
   output logic [1:0]        blk_hdr_o,
   output logic              blk_valid_o,
   output logic              locked_o,
   output logic              lock_lost_o,
   output logic [OFFS_W-1:0] lock_offset_o
);

   localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int unsigned ERR_W  = $clog2(ERR_MAX + 1);
   localparam int unsigned WIN_W  = $clog2(WINDOW);

   localparam logic [GOOD_W-1:0] GoodLast = GOOD_W'(LOCK_CNT - 1);
   localparam logic [GOOD_W-1:0] GoodMax  = GOOD_W'(LOCK_CNT);
   localparam logic [ERR_W-1:0]  ErrLast  = ERR_W'(ERR_MAX - 1);
   localparam logic [WIN_W-1:0]  BlkLast  = WIN_W'(WINDOW - 1);

   sync_state_t       state_q, state_d;
   logic [OFFS_W-1:0] lock_offset_q, lock_offset_d;
   logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
   logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
   logic [WIN_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic [BLK_W-1:0]  blk_data_q, blk_data_d;
   logic [1:0]        blk_hdr_q, blk_hdr_d;
   logic              blk_valid_q, blk_valid_d;
   logic              lock_lost_q, lock_lost_d;
   logic              emit;

   logic [1:0]        cand_hdr, lock_hdr;
   logic [BLK_W-1:0]  cand_data, lock_data;
   logic              cand_ok, lock_ok;
   logic              unused_cand;

   block_slicer u_cand_slicer (
      .gbox_buffer_i (gbox_buffer),
      .gbox_cnt_i    (gbox_cnt),
      .offset_i      (block_offset),
      .hdr_o         (cand_hdr),
      .data_o        (cand_data),
      .hdr_ok_o      (cand_ok)
   );

   block_slicer u_lock_slicer (
      .gbox_buffer_i (gbox_buffer),
      .gbox_cnt_i    (gbox_cnt),
      .offset_i      (lock_offset_q),
      .hdr_o         (lock_hdr),
      .data_o        (lock_data),
      .hdr_ok_o      (lock_ok)
   );

   // The HUNT candidate only contributes its header-good flag.
   assign unused_cand = ^{cand_hdr, cand_data};

   always_comb begin
      state_d       = state_q;
      lock_offset_d = lock_offset_q;
      good_cnt_d    = good_cnt_q;
      err_cnt_d     = err_cnt_q;
      blk_cnt_d     = blk_cnt_q;
      blk_data_d    = blk_data_q;
      blk_hdr_d     = blk_hdr_q;
      blk_valid_d   = 1'b0;
      lock_lost_d   = 1'b0;
      emit          = 1'b0;

      if (relock_i) begin
         state_d     = HUNT;
         good_cnt_d  = '0;
         err_cnt_d   = '0;
         blk_cnt_d   = '0;
         lock_lost_d = (state_q == LOCKED);
      end else if (buffer_dv) begin
         unique case (state_q)
            HUNT: begin
               if (cand_ok) begin
                  state_d       = CHECK;
                  lock_offset_d = block_offset;
                  good_cnt_d    = GOOD_W'(1);
               end
            end
            CHECK: begin
               if (!lock_ok) begin
                  state_d    = HUNT;
                  good_cnt_d = '0;
               end else if (good_cnt_q >= GoodLast) begin
                  // The block completing the run is the first one emitted; the
                  // error window starts with the block after it.
                  state_d    = LOCKED;
                  good_cnt_d = GoodMax;
                  err_cnt_d  = '0;
                  blk_cnt_d  = '0;
                  emit       = 1'b1;
               end else begin
                  good_cnt_d = good_cnt_q + 1'b1;
               end
            end
            LOCKED: begin
               emit = 1'b1;
               if (!lock_ok && (err_cnt_q >= ErrLast)) begin
                  state_d     = HUNT;
                  lock_lost_d = 1'b1;
                  good_cnt_d  = '0;
                  err_cnt_d   = '0;
                  blk_cnt_d   = '0;
               end else if (blk_cnt_q == BlkLast) begin
                  blk_cnt_d = '0;
                  err_cnt_d = lock_ok ? ERR_W'(0) : ERR_W'(1);
               end else begin
                  blk_cnt_d = blk_cnt_q + 1'b1;
                  if (!lock_ok) begin
                     err_cnt_d = err_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (emit) begin
         blk_valid_d = 1'b1;
         blk_data_d  = lock_data;
         blk_hdr_d   = lock_hdr;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= HUNT;
         lock_offset_q <= '0;
         good_cnt_q    <= '0;
         err_cnt_q     <= '0;
         blk_cnt_q     <= '0;
         blk_data_q    <= '0;
         blk_hdr_q     <= '0;
         blk_valid_q   <= 1'b0;
         lock_lost_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         lock_offset_q <= lock_offset_d;
         good_cnt_q    <= good_cnt_d;
         err_cnt_q     <= err_cnt_d;
         blk_cnt_q     <= blk_cnt_d;
         blk_data_q    <= blk_data_d;
         blk_hdr_q     <= blk_hdr_d;
         blk_valid_q   <= blk_valid_d;
         lock_lost_q   <= lock_lost_d;
      end
   end

   assign blk_data_o    = blk_data_q;
   assign blk_hdr_o     = blk_hdr_q;
   assign blk_valid_o   = blk_valid_q;
   assign locked_o      = (state_q == LOCKED);
   assign lock_lost_o   = lock_lost_q;
   assign lock_offset_o = lock_offset_q;

endmodule

// File: tb/tb_block_sync.sv
// Bench for block_sync: directed block streams, a block-level reference model checked
// every cycle, plus literal spot checks on key events.
module tb_block_sync;
   import rx_block_pkg::*;

   localparam int LOCK_CNT = 32;
   localparam int ERR_MAX  = 16;
   localparam int WINDOW   = 64;
   localparam logic [63:0] LIT_A = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] LIT_B = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] LIT_C = 64'hF0E1_D2C3_B4A5_9687;

   logic         clk_i = 1'b0;
   logic         rst_ni = 1'b0;
   logic [193:0] gbox_buffer = '0;
   logic [5:0]   gbox_cnt = '0;
   logic         buffer_dv = 1'b0;
   logic [6:0]   block_offset = '0;
   logic         relock_i = 1'b0;
   logic [63:0]  blk_data_o;
   logic [1:0]   blk_hdr_o;
   logic         blk_valid_o, locked_o, lock_lost_o;
   logic [6:0]   lock_offset_o;

   int n_cmp = 0;
   int n_fail = 0;
   bit run_chk = 1'b0;

   block_sync #(
      .LOCK_CNT (LOCK_CNT),
      .ERR_MAX  (ERR_MAX),
      .WINDOW   (WINDOW)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .gbox_buffer   (gbox_buffer),
      .gbox_cnt      (gbox_cnt),
      .buffer_dv     (buffer_dv),
      .block_offset  (block_offset),
      .relock_i      (relock_i),
      .blk_data_o    (blk_data_o),
      .blk_hdr_o     (blk_hdr_o),
      .blk_valid_o   (blk_valid_o),
      .locked_o      (locked_o),
      .lock_lost_o   (lock_lost_o),
      .lock_offset_o (lock_offset_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (block-level) ----------------
   // mode: 0 hunting, 1 checking, 2 locked. k counts blocks since lock; the error
   // window of block k is (k+1)/WINDOW (the window rolls on its last block).
   int          m_mode, m_offs, m_streak, m_k, m_win, m_errs;
   logic [63:0] e_data;
   logic [1:0]  e_hdr;
   logic        e_valid, e_locked, e_lost;
   logic [6:0]  e_offs;

   function automatic void slice(input logic [193:0] b, input int c, input int o,
                                 output logic [1:0] h, output logic [63:0] d);
      int base;
      base = 127 - c + o;
      h = {b[base + 1], b[base]};
      for (int i = 0; i < 64; i++) d[i] = b[base - 64 + i];
   endfunction

   function automatic bit good(input logic [1:0] h);
      return (h == 2'b01) || (h == 2'b10);
   endfunction

   always @(posedge clk_i or negedge rst_ni) begin
      logic [1:0]  h;
      logic [63:0] d;
      if (!rst_ni) begin
         m_mode = 0; m_offs = 0; m_streak = 0; m_k = 0; m_win = 0; m_errs = 0;
         e_data = '0; e_hdr = '0; e_valid = 0; e_locked = 0; e_lost = 0; e_offs = '0;
      end else begin
         e_valid = 0;
         e_lost  = 0;
         if (relock_i) begin
            e_lost   = (m_mode == 2);
            m_mode   = 0;
            m_streak = 0;
         end else if (buffer_dv) begin
            if (m_mode == 0) begin
               slice(gbox_buffer, int'(gbox_cnt), int'(block_offset), h, d);
               if (good(h)) begin
                  m_mode = 1; m_offs = int'(block_offset); m_streak = 1;
               end
            end else begin
               slice(gbox_buffer, int'(gbox_cnt), m_offs, h, d);
               if (m_mode == 1) begin
                  if (!good(h)) begin
                     m_mode = 0; m_streak = 0;
                  end else begin
                     m_streak++;
                     if (m_streak == LOCK_CNT) begin
                        m_mode = 2; m_k = 0; m_win = 0; m_errs = 0;
                        e_valid = 1; e_data = d; e_hdr = h;
                     end
                  end
               end else begin
                  e_valid = 1; e_data = d; e_hdr = h;
                  if ((m_k + 1) / WINDOW != m_win) begin
                     m_win  = (m_k + 1) / WINDOW;
                     m_errs = 0;
                  end
                  if (!good(h)) m_errs++;
                  m_k++;
                  if (m_errs == ERR_MAX) begin
                     m_mode = 0; m_streak = 0; e_lost = 1;
                  end
               end
            end
         end
         e_locked = (m_mode == 2);
         e_offs   = 7'(m_offs);
      end
   end

   always @(negedge clk_i) begin
      if (run_chk && rst_ni) begin
         chk("valid", 64'(blk_valid_o), 64'(e_valid));
         chk("locked", 64'(locked_o), 64'(e_locked));
         chk("lock_lost", 64'(lock_lost_o), 64'(e_lost));
         chk("data", blk_data_o, e_data);
         chk("hdr", 64'(blk_hdr_o), 64'(e_hdr));
         if (m_mode != 0) chk("lock_offset", 64'(lock_offset_o), 64'(e_offs));
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [63:0] pat(input int i);
      return 64'h5A5A_3C3C_0F0F_9696 ^ (64'(i) * 64'h9E37_79B9_7F4A_7C15);
   endfunction

   // Drives one block placed at offset po, sampled on the next clock edge.
   task automatic send(input int po, input int c, input logic [1:0] h, input logic [63:0] d,
                       input int bo, input bit rl);
      logic [193:0] b;
      int base;
      for (int i = 0; i < 194; i++) b[i] = 1'($urandom_range(0, 1));
      base = 127 - c + po;
      b[base + 1] = h[1];
      b[base]     = h[0];
      for (int i = 0; i < 64; i++) b[base - 64 + i] = d[i];
      gbox_buffer  = b;
      gbox_cnt     = 6'(c);
      block_offset = 7'(bo);
      relock_i     = rl;
      buffer_dv    = 1'b1;
      @(posedge clk_i);
      #2;
      buffer_dv = 1'b0;
      relock_i  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #2;
      end
   endtask

   // n good blocks at offset o; cfix < 0 sweeps cnt. block_offset only steers HUNT.
   task automatic lock_run(input int o, input int n, input int cfix, input logic [63:0] last);
      for (int i = 0; i < n; i++) begin
         int c;
         c = (cfix < 0) ? (i % 64) : cfix;
         if (i % 7 == 3) idle(1);
         send(o, c, (i == n - 1) ? 2'b10 : ((i % 2 == 1) ? 2'b10 : 2'b01),
              (i == n - 1) ? last : pat(i), (i == 0) ? o : (o + 11) % 66, 1'b0);
      end
   endtask

   task automatic pulse_relock();
      relock_i = 1'b1;
      @(posedge clk_i);
      #2;
      relock_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk_i);
      #2;
      rst_ni  = 1'b1;
      run_chk = 1'b1;
      idle(1);
      chk("rst_locked", 64'(locked_o), 64'd0);
      chk("rst_valid", 64'(blk_valid_o), 64'd0);
      chk("rst_data", blk_data_o, 64'd0);
      chk("rst_offset", 64'(lock_offset_o), 64'd0);

      // Clean stream at offset 17: lock on the 32nd good block.
      lock_run(17, 31, -1, pat(30));
      chk("pre_lock_locked", 64'(locked_o), 64'd0);
      send(17, 31, 2'b10, LIT_A, 40, 1'b0);
      chk("lock_locked", 64'(locked_o), 64'd1);
      chk("lock_valid", 64'(blk_valid_o), 64'd1);
      chk("lock_data", blk_data_o, LIT_A);
      chk("lock_offset", 64'(lock_offset_o), 64'd17);
      idle(1);
      chk("hold_data", blk_data_o, LIT_A);

      // 15 bad headers in one window keep lock; the 16th drops it.
      for (int i = 0; i < 15; i++) send(17, 9, (i % 2 == 0) ? 2'b00 : 2'b11, pat(i), 17, 1'b0);
      chk("err15_locked", 64'(locked_o), 64'd1);
      send(17, 9, 2'b11, LIT_B, 17, 1'b0);
      chk("err16_lost", 64'(lock_lost_o), 64'd1);
      chk("err16_locked", 64'(locked_o), 64'd0);
      chk("err16_emit_hdr", 64'(blk_hdr_o), 64'd3);
      chk("err16_emit_data", blk_data_o, LIT_B);
      idle(1);
      chk("lost_pulse_end", 64'(lock_lost_o), 64'd0);

      // 8 bad at the end of a window and 8 after the roll: no loss.
      lock_run(17, 32, -1, pat(99));
      for (int i = 0; i < 56; i++) send(17, (i * 5) % 64, 2'b01, pat(i), 3, 1'b0);
      for (int i = 0; i < 16; i++) send(17, (i * 3) % 64, 2'b00, pat(i), 3, 1'b0);
      for (int i = 0; i < 4; i++) send(17, i, 2'b10, pat(i), 3, 1'b0);
      chk("window_locked", 64'(locked_o), 64'd1);

      // relock_i together with buffer_dv while locked.
      send(17, 7, 2'b01, LIT_C, 17, 1'b1);
      chk("relock_lost", 64'(lock_lost_o), 64'd1);
      chk("relock_valid", 64'(blk_valid_o), 64'd0);
      chk("relock_locked", 64'(locked_o), 64'd0);

      // Bad header at good_cnt 20 returns to HUNT; next good block re-seeds offset.
      lock_run(5, 20, -1, pat(7));
      send(5, 21, 2'b11, pat(8), 5, 1'b0);
      chk("check_fail_locked", 64'(locked_o), 64'd0);
      chk("check_fail_valid", 64'(blk_valid_o), 64'd0);
      send(40, 2, 2'b01, pat(9), 40, 1'b0);
      chk("rehunt_offset", 64'(lock_offset_o), 64'd40);
      pulse_relock();
      chk("relock_check_lost", 64'(lock_lost_o), 64'd0);

      // Offset extremes.
      lock_run(0, 32, 63, LIT_B);
      chk("o0_c63_data", blk_data_o, LIT_B);
      chk("o0_c63_hdr", 64'(blk_hdr_o), 64'd2);
      pulse_relock();
      lock_run(65, 32, 0, LIT_C);
      chk("o65_c0_data", blk_data_o, LIT_C);
      chk("o65_c0_offset", 64'(lock_offset_o), 64'd65);

      // Asynchronous reset in the middle of a clock period.
      send(65, 0, 2'b01, pat(1), 65, 1'b0);
      @(posedge clk_i);
      #3;
      rst_ni = 1'b0;
      #1;
      chk("arst_locked", 64'(locked_o), 64'd0);
      chk("arst_valid", 64'(blk_valid_o), 64'd0);
      chk("arst_data", blk_data_o, 64'd0);
      chk("arst_offset", 64'(lock_offset_o), 64'd0);
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
